imem_axi_rd_responder: RTL and testbench

AXI4 read-only responder that serves instruction fetch bursts from an on-chip word-addressed RAM. It is the other end of the instruction-memory DDR read channel: the instruction loader issues AR bursts and this block returns R beats. It is used as a synthesizable instruction store and as the DDR model in block-level benches. The RAM is preloaded through a simple write port.

---
 rtl/imem_axi_rd_responder.sv | 237 +++++++++++++++++++++++
 tb/tb_imem_axi_rd_responder.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_axi_rd_responder.sv
// AXI4 INCR read responder serving bursts from an on-chip word RAM.
// Define IMEM_RESP_AR_QUEUE_EN to add a one-entry AR holding register.
module imem_axi_rd_responder #(
    parameter int AXI_ADDR_WIDTH  = 42,
    parameter int AXI_DATA_WIDTH  = 64,
    parameter int AXI_BURST_WIDTH = 8,
    parameter int MEM_ADDR_WIDTH  = 12
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [AXI_ADDR_WIDTH-1:0]  araddr,
    input  logic [AXI_BURST_WIDTH-1:0] arlen,
    input  logic                       arvalid,
    output logic                       arready,
    output logic [AXI_DATA_WIDTH-1:0]  rdata,
    output logic                       rlast,
    output logic                       rvalid,
    input  logic                       rready,
    input  logic                       load_we,
    input  logic [MEM_ADDR_WIDTH-1:0]  load_addr,
    input  logic [AXI_DATA_WIDTH-1:0]  load_data,
    output logic                       busy
);
    localparam int B     = $clog2(AXI_DATA_WIDTH / 8);
    localparam int DEPTH = 1 << MEM_ADDR_WIDTH;
`ifdef IMEM_RESP_AR_QUEUE_EN
    localparam logic QEN = 1'b1;
`else
    localparam logic QEN = 1'b0;
`endif

    typedef enum logic {S_IDLE, S_BURST} state_t;
    state_t r_state;
    state_t w_next;

    logic [AXI_DATA_WIDTH-1:0]  r_mem [DEPTH];
    logic [AXI_DATA_WIDTH-1:0]  r_rdata;
    logic                       r_rd_vld;
    logic                       r_rd_last;

    logic                       r_act;
    logic [MEM_ADDR_WIDTH-1:0]  r_idx;
    logic [AXI_BURST_WIDTH-1:0] r_len;
    logic [2:0]                 r_nb;

    logic [1:0]                 r_fcnt;
    logic [AXI_DATA_WIDTH-1:0]  r_d0;
    logic [AXI_DATA_WIDTH-1:0]  r_d1;
    logic                       r_l0;
    logic                       r_l1;

    logic                       w_q_vld;
    logic [MEM_ADDR_WIDTH-1:0]  w_q_idx;
    logic [AXI_BURST_WIDTH-1:0] w_q_len;

    logic [MEM_ADDR_WIDTH-1:0]  w_ar_idx;
    logic [2:0]                 w_occ;
    logic                       w_ar_hs;
    logic                       w_pop;
    logic                       w_push;
    logic                       w_last_pop;
    logic                       w_space;
    logic                       w_issue;
    logic                       w_last_rd;
    logic                       w_unused_addr;

    assign w_unused_addr = ^araddr;
    assign w_ar_idx      = araddr[MEM_ADDR_WIDTH+B-1:B];
    assign w_ar_hs       = arvalid & arready;

    assign rvalid     = (r_fcnt != 2'd0);
    assign rdata      = r_d0;
    assign rlast      = r_l0 & rvalid;
    assign w_pop      = rvalid & rready;
    assign w_push     = r_rd_vld;
    assign w_last_pop = w_pop & r_l0;

    // Count the in-flight RAM read so the skid buffer can never overflow.
    assign w_occ     = {1'b0, r_fcnt} + {2'b00, r_rd_vld} - {2'b00, w_pop};
    assign w_space   = (w_occ <= 3'd1);
    assign w_issue   = r_act & w_space;
    assign w_last_rd = w_issue & (r_len == '0);

`ifdef IMEM_RESP_AR_QUEUE_EN
    logic                       r_q_vld;
    logic [MEM_ADDR_WIDTH-1:0]  r_q_idx;
    logic [AXI_BURST_WIDTH-1:0] r_q_len;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_q_vld <= 1'b0;
            r_q_idx <= '0;
            r_q_len <= '0;
        end else if ((w_last_rd || !r_act) && r_q_vld) begin
            r_q_vld <= 1'b0;
        end else if (w_ar_hs && r_act && !w_last_rd) begin
            r_q_vld <= 1'b1;
            r_q_idx <= w_ar_idx;
            r_q_len <= arlen;
        end
    end

    assign w_q_vld = r_q_vld;
    assign w_q_idx = r_q_idx;
    assign w_q_len = r_q_len;
`else
    assign w_q_vld = 1'b0;
    assign w_q_idx = '0;
    assign w_q_len = '0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_act <= 1'b0;
            r_idx <= '0;
            r_len <= '0;
        end else begin
            if (w_issue) begin
                r_idx <= r_idx + MEM_ADDR_WIDTH'(1);
                r_len <= r_len - AXI_BURST_WIDTH'(1);
            end
            if (w_last_rd || !r_act) begin
                if (w_q_vld) begin
                    r_act <= 1'b1;
                    r_idx <= w_q_idx;
                    r_len <= w_q_len;
                end else if (w_ar_hs) begin
                    r_act <= 1'b1;
                    r_idx <= w_ar_idx;
                    r_len <= arlen;
                end else begin
                    r_act <= 1'b0;
                end
            end
        end
    end

    // Read-first: the read samples the array before this edge's write lands.
    always_ff @(posedge clk) begin
        if (w_issue)
            r_rdata <= r_mem[r_idx];
        if (load_we)
            r_mem[load_addr] <= load_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_vld  <= 1'b0;
            r_rd_last <= 1'b0;
        end else begin
            r_rd_vld  <= w_issue;
            r_rd_last <= w_last_rd;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fcnt <= 2'd0;
            r_d0   <= '0;
            r_d1   <= '0;
            r_l0   <= 1'b0;
            r_l1   <= 1'b0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_fcnt == 2'd0) begin
                        r_d0 <= r_rdata;
                        r_l0 <= r_rd_last;
                    end else begin
                        r_d1 <= r_rdata;
                        r_l1 <= r_rd_last;
                    end
                    r_fcnt <= r_fcnt + 2'd1;
                end
                2'b01: begin
                    r_d0   <= r_d1;
                    r_l0   <= r_l1;
                    r_fcnt <= r_fcnt - 2'd1;
                end
                2'b11: begin
                    if (r_fcnt == 2'd1) begin
                        r_d0 <= r_rdata;
                        r_l0 <= r_rd_last;
                    end else begin
                        r_d0 <= r_d1;
                        r_l0 <= r_l1;
                        r_d1 <= r_rdata;
                        r_l1 <= r_rd_last;
                    end
                end
                default: ;
            endcase
        end
    end

    // Bursts accepted but whose last beat has not yet been handed off.
    always_ff @(posedge clk) begin
        if (reset)
            r_nb <= 3'd0;
        else
            r_nb <= r_nb + {2'b00, w_ar_hs} - {2'b00, w_last_pop};
    end

    always_ff @(posedge clk) begin
        if (reset)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:
                if (w_ar_hs)
                    w_next = S_BURST;
            S_BURST:
                if (w_last_pop && r_nb == 3'd1 && !w_ar_hs)
                    w_next = S_IDLE;
            default:
                w_next = S_IDLE;
        endcase
    end

    always_comb begin
        arready = 1'b0;
        busy    = 1'b0;
        case (r_state)
            S_IDLE: arready = ~reset;
            S_BURST: begin
                busy    = 1'b1;
                arready = ~reset & QEN & ~w_q_vld;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_imem_axi_rd_responder.sv
// Directed self-checking bench for imem_axi_rd_responder (16-word RAM).
// Queue scenario is compiled in when IMEM_RESP_AR_QUEUE_EN is defined.
module tb_imem_axi_rd_responder;
    localparam int AW = 42;
    localparam int DW = 64;
    localparam int LW = 8;
    localparam int MW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [AW-1:0] araddr = '0;
    logic [LW-1:0] arlen = '0;
    logic          arvalid = 1'b0;
    logic          arready;
    logic [DW-1:0] rdata;
    logic          rlast;
    logic          rvalid;
    logic          rready = 1'b0;
    logic          load_we = 1'b0;
    logic [MW-1:0] load_addr = '0;
    logic [DW-1:0] load_data = '0;
    logic          busy;

    int checks = 0;
    int failures = 0;

    logic [DW-1:0] got_d [0:15];
    logic          got_l [0:15];
    int            got_n;
    int            first_lat;
    int            stall_bad;
    int            stalls;
    int            gaps;
    int            ar_during;
    int            busy_low;
    logic          ar_ok;
    logic          busy_after;
    logic [31:0]   pat = 32'b1011_0011_0100_1110_0101_1001_1100_0110;

    imem_axi_rd_responder #(
        .AXI_ADDR_WIDTH(AW),
        .AXI_DATA_WIDTH(DW),
        .AXI_BURST_WIDTH(LW),
        .MEM_ADDR_WIDTH(MW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .araddr(araddr),
        .arlen(arlen),
        .arvalid(arvalid),
        .arready(arready),
        .rdata(rdata),
        .rlast(rlast),
        .rvalid(rvalid),
        .rready(rready),
        .load_we(load_we),
        .load_addr(load_addr),
        .load_data(load_data),
        .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic load_word(input int a, input logic [DW-1:0] d);
        @(negedge clk);
        load_we = 1'b1;
        load_addr = MW'(a);
        load_data = d;
        @(negedge clk);
        load_we = 1'b0;
    endtask

    // mode 0: rready high; 1: rready pattern; 2: word-5 write at cycle 2
    task automatic fetch(input logic [AW-1:0] addr, input logic [LW-1:0] len,
                         input int mode);
        logic [DW-1:0] hd;
        logic hl;
        logic hold;
        got_n = 0; first_lat = -1; stall_bad = 0; stalls = 0; gaps = 0;
        ar_during = 0; busy_low = 0; ar_ok = 1'b0;
        hold = 1'b0; hd = '0; hl = 1'b0;
        @(negedge clk);
        araddr = addr; arlen = len; arvalid = 1'b1;
        for (int c = 0; c < 20 && !ar_ok; c++) begin
            if (arready) ar_ok = 1'b1;
            @(negedge clk);
        end
        arvalid = 1'b0;
        if (!ar_ok) return;
        for (int c = 1; c < 300 && got_n <= int'(len); c++) begin
            if (hold) begin
                stalls++;
                if (!rvalid || rdata !== hd || rlast !== hl) stall_bad++;
            end
            if (rvalid && first_lat < 0) first_lat = c;
            if (first_lat >= 0 && !rvalid) gaps++;
            if (arready) ar_during++;
            if (!busy) busy_low++;
            rready = (mode == 1) ? pat[c % 32] : 1'b1;
            if (mode == 2) begin
                load_we = (c == 2);
                load_addr = 4'd5;
                load_data = 64'hBEEF;
            end
            if (rvalid && rready) begin
                if (got_n < 16) begin
                    got_d[got_n] = rdata;
                    got_l[got_n] = rlast;
                end
                got_n++;
                hold = 1'b0;
            end else begin
                hold = rvalid;
            end
            hd = rdata; hl = rlast;
            @(negedge clk);
        end
        load_we = 1'b0;
        rready = 1'b0;
        busy_after = busy;
    endtask

    task automatic test_reset;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({rvalid, rlast, busy, arready} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_ctl got=%b exp=0000",
                     {rvalid, rlast, busy, arready});
        end
        checks++;
        if (rdata !== '0) begin
            failures++;
            $display("FAIL reset_rdata got=%h exp=0", rdata);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (arready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL post_reset arready=%b busy=%b exp 1 0",
                     arready, busy);
        end
    endtask

    task automatic test_basic;
        fetch(42'h40, 8'd3, 0);
        checks++;
        if (got_n != 4) begin
            failures++;
            $display("FAIL basic_count got=%0d exp=4", got_n);
        end
        checks++;
        if (first_lat != 3) begin
            failures++;
            $display("FAIL basic_latency got=%0d exp=3", first_lat);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (got_d[i] !== 64'h1008 + 64'(i) || got_l[i] !== (i == 3)) begin
                failures++;
                $display("FAIL basic_beat%0d got=%h/%b exp=%h/%b", i,
                         got_d[i], got_l[i], 64'h1008 + 64'(i), i == 3);
            end
        end
        checks++;
        if (gaps != 0 || busy_low != 0) begin
            failures++;
            $display("FAIL basic_flow gaps=%0d busy_low=%0d exp 0 0",
                     gaps, busy_low);
        end
        checks++;
        if (busy_after !== 1'b0) begin
            failures++;
            $display("FAIL basic_busy_after got=%b exp=0", busy_after);
        end
`ifndef IMEM_RESP_AR_QUEUE_EN
        checks++;
        if (ar_during != 0) begin
            failures++;
            $display("FAIL basic_arready_busy got=%0d exp=0", ar_during);
        end
`endif
    endtask

    task automatic test_unaligned;
        fetch(42'h43, 8'd0, 0);
        checks++;
        if (got_n != 1 || got_d[0] !== 64'h1008 || got_l[0] !== 1'b1) begin
            failures++;
            $display("FAIL unaligned got n=%0d %h/%b exp n=1 1008/1",
                     got_n, got_d[0], got_l[0]);
        end
        fetch(42'h3_0000_0048, 8'd0, 0);
        checks++;
        if (got_n != 1 || got_d[0] !== 64'h1009 || got_l[0] !== 1'b1) begin
            failures++;
            $display("FAIL upper_bits got n=%0d %h/%b exp n=1 1009/1",
                     got_n, got_d[0], got_l[0]);
        end
    endtask

    task automatic test_wrap;
        logic [DW-1:0] exp_d [0:3];
        exp_d[0] = 64'h100E; exp_d[1] = 64'h100F;
        exp_d[2] = 64'h1000; exp_d[3] = 64'h1001;
        fetch(42'h70, 8'd3, 0);
        checks++;
        if (got_n != 4 || gaps != 0) begin
            failures++;
            $display("FAIL wrap_flow n=%0d gaps=%0d exp 4 0", got_n, gaps);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (got_d[i] !== exp_d[i] || got_l[i] !== (i == 3)) begin
                failures++;
                $display("FAIL wrap_beat%0d got=%h/%b exp=%h/%b", i,
                         got_d[i], got_l[i], exp_d[i], i == 3);
            end
        end
    endtask

    task automatic test_stall;
        fetch(42'h0, 8'd7, 1);
        checks++;
        if (got_n != 8) begin
            failures++;
            $display("FAIL stall_count got=%0d exp=8", got_n);
        end
        checks++;
        if (stall_bad != 0 || stalls == 0) begin
            failures++;
            $display("FAIL stall_hold bad=%0d stalls=%0d exp 0 >0",
                     stall_bad, stalls);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (got_d[i] !== 64'h1000 + 64'(i) || got_l[i] !== (i == 7)) begin
                failures++;
                $display("FAIL stall_beat%0d got=%h/%b exp=%h/%b", i,
                         got_d[i], got_l[i], 64'h1000 + 64'(i), i == 7);
            end
        end
    endtask

    task automatic test_collision;
        fetch(42'h20, 8'd3, 2);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (got_d[i] !== 64'h1004 + 64'(i)) begin
                failures++;
                $display("FAIL collide_beat%0d got=%h exp=%h", i,
                         got_d[i], 64'h1004 + 64'(i));
            end
        end
        fetch(42'h28, 8'd0, 0);
        checks++;
        if (got_n != 1 || got_d[0] !== 64'hBEEF) begin
            failures++;
            $display("FAIL collide_reread got=%h exp=beef", got_d[0]);
        end
        load_word(5, 64'h1005);
    endtask

    task automatic test_reset_mid;
        int n;
        logic ok;
        int late;
        ok = 1'b0; n = 0; late = 0;
        @(negedge clk);
        araddr = 42'h0; arlen = 8'd7; arvalid = 1'b1; rready = 1'b1;
        for (int c = 0; c < 20 && !ok; c++) begin
            if (arready) ok = 1'b1;
            @(negedge clk);
        end
        arvalid = 1'b0;
        for (int c = 0; c < 20 && n < 2; c++) begin
            if (rvalid && rready) n++;
            @(negedge clk);
        end
        checks++;
        if (n != 2) begin
            failures++;
            $display("FAIL rstmid_beats got=%0d exp=2", n);
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({rvalid, rlast, busy, arready} !== 4'b0000 || rdata !== '0) begin
            failures++;
            $display("FAIL rstmid_outputs got=%b rdata=%h exp=0000 0",
                     {rvalid, rlast, busy, arready}, rdata);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (arready !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_arready got=%b exp=1", arready);
        end
        for (int c = 0; c < 4; c++) begin
            if (rvalid) late++;
            @(negedge clk);
        end
        checks++;
        if (late != 0) begin
            failures++;
            $display("FAIL rstmid_partial got=%0d exp=0", late);
        end
        rready = 1'b0;
        fetch(42'h10, 8'd1, 0);
        checks++;
        if (got_n != 2 || got_d[0] !== 64'h1002 || got_d[1] !== 64'h1003
            || got_l[0] !== 1'b0 || got_l[1] !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_after got n=%0d %h %h exp 2 1002 1003",
                     got_n, got_d[0], got_d[1]);
        end
    endtask

`ifdef IMEM_RESP_AR_QUEUE_EN
    task automatic test_queue;
        int st;
        int n;
        int nl;
        int gap;
        logic pend;
        logic started;
        logic [DW-1:0] exp_d [0:5];
        exp_d[0] = 64'h1000; exp_d[1] = 64'h1001; exp_d[2] = 64'h1002;
        exp_d[3] = 64'h1003; exp_d[4] = 64'h1008; exp_d[5] = 64'h1009;
        st = 0; n = 0; nl = 0; gap = 0; pend = 1'b0; started = 1'b0;
        rready = 1'b1;
        @(negedge clk);
        araddr = 42'h0; arlen = 8'd3; arvalid = 1'b1;
        for (int c = 0; c < 80 && n < 6; c++) begin
            if (pend) begin
                st++;
                pend = 1'b0;
                if (st == 1) begin
                    araddr = 42'h40; arlen = 8'd1;
                end else begin
                    arvalid = 1'b0;
                end
            end
            if (arvalid && arready) pend = 1'b1;
            if (rvalid) begin
                started = 1'b1;
                if (n < 6) begin
                    got_d[n] = rdata;
                    got_l[n] = rlast;
                end
                if (rlast) nl++;
                n++;
            end else if (started) begin
                gap++;
            end
            @(negedge clk);
        end
        arvalid = 1'b0;
        rready = 1'b0;
        checks++;
        if (n != 6 || nl != 2 || gap != 0) begin
            failures++;
            $display("FAIL queue_flow n=%0d rlasts=%0d gaps=%0d exp 6 2 0",
                     n, nl, gap);
        end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (got_d[i] !== exp_d[i]) begin
                failures++;
                $display("FAIL queue_beat%0d got=%h exp=%h", i,
                         got_d[i], exp_d[i]);
            end
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL queue_busy_after got=%b exp=0", busy);
        end
    endtask
`endif

    initial begin
        test_reset();
        for (int i = 0; i < 16; i++)
            load_word(i, 64'h1000 + 64'(i));
        test_basic();
        test_unaligned();
        test_wrap();
        test_stall();
        test_collision();
        test_reset_mid();
`ifdef IMEM_RESP_AR_QUEUE_EN
        test_queue();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
